// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the DRAM round-robin arbiter.
package dram_arb_pkg;

    localparam int STATE_W = 2;

    // Wait counter only has to hold RD_LAT-1, and RD_LAT never exceeds 7.
    localparam int CNT_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Width of a requester index; N_REQ is always at least 2.
    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Requester-side and DRAM-side signals of the arbiter.
// slave: the arbiter's view. master: the cores plus DRAM macro.
interface dram_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dram_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester found scanning from last+1.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan from the farthest candidate down to the nearest so the nearest one after last wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last) + off) % N_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing a single-port DRAM among N_REQ cores.
//
// state | meaning
// IDLE  | waiting for any req; winner and payload latched on exit
// ISSUE | one cycle: gnt to winner, single mem_en pulse
// WAIT  | read only: count down RD_LAT-1..0, capture mem_rdata at 0
// RESP  | one cycle: done to winner, winner becomes lowest priority
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    dram_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(N_REQ);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  win_oh;
    logic [N_REQ-1:0]  gnt_c;
    logic [N_REQ-1:0]  done_c;
    logic              mem_en_c;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (bus.req),
        .last  (last_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign win_oh = N_REQ'(1) << win_q;

    // Next-state, payload latch and pulse outputs of the transaction sequencer.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        gnt_c    = '0;
        done_c   = '0;
        mem_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_idx;
                    we_d    = bus.we[pick_idx];
                    addr_d  = bus.addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wdata_d = bus.wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                gnt_c    = win_oh;
                mem_en_c = 1'b1;
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = bus.mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                done_c  = win_oh;
                last_d  = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-payload registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // The latched payload only changes on entry to ISSUE, so it doubles as the held DRAM bus.
    assign bus.gnt       = gnt_c;
    assign bus.done      = done_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed N_REQ=2/RD_LAT=1 checks, then randomized
// N_REQ=4/RD_LAT=3 traffic against a transaction-schedule reference model.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    localparam int N0 = 4, L0 = 3, N1 = 2, L1 = 1, AW = 16, DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;

    dram_arbiter_if #(.N_REQ(N0), .ADDR_W(AW), .DATA_W(DW)) if0 ();
    dram_arbiter_if #(.N_REQ(N1), .ADDR_W(AW), .DATA_W(DW)) if1 ();

    dram_arbiter #(.N_REQ(N0), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(L0)) u0 (
        .clk(clk), .rst(rst0), .bus(if0.slave));
    dram_arbiter #(.N_REQ(N1), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(L1)) u1 (
        .clk(clk), .rst(rst1), .bus(if1.slave));

    function automatic logic [DW-1:0] init_val(input logic [7:0] a);
        return {a, ~a};
    endfunction

    // DRAM macro models: writes on mem_en&mem_we, read data appears exactly RD_LAT cycles later.
    logic [DW-1:0] dmem0 [0:255];
    bit            dwr0  [0:255];
    logic [DW-1:0] pipe0 [L0];
    always @(posedge clk) begin
        if (if0.mem_en && if0.mem_we) begin
            dmem0[if0.mem_addr[7:0]] <= if0.mem_wdata;
            dwr0[if0.mem_addr[7:0]]  <= 1'b1;
        end
        pipe0[0] <= (if0.mem_en && !if0.mem_we) ?
                    (dwr0[if0.mem_addr[7:0]] ? dmem0[if0.mem_addr[7:0]] : init_val(if0.mem_addr[7:0]))
                    : 16'hDEAD;
        for (int i = 1; i < L0; i++) pipe0[i] <= pipe0[i-1];
    end
    assign if0.mem_rdata = pipe0[L0-1];

    logic [DW-1:0] dmem1 [0:255];
    bit            dwr1  [0:255];
    logic [DW-1:0] rd1;
    always @(posedge clk) begin
        if (if1.mem_en && if1.mem_we) begin
            dmem1[if1.mem_addr[7:0]] <= if1.mem_wdata;
            dwr1[if1.mem_addr[7:0]]  <= 1'b1;
        end
        rd1 <= (if1.mem_en && !if1.mem_we) ?
               (dwr1[if1.mem_addr[7:0]] ? dmem1[if1.mem_addr[7:0]] : init_val(if1.mem_addr[7:0]))
               : 16'hDEAD;
    end
    assign if1.mem_rdata = rd1;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: one scheduled transaction (grant cycle, done cycle, latched payload).
    int            cyc;
    int            m_gnt_cyc, m_done_cyc, m_last, m_win;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rval, exp_rdata;
    logic [DW-1:0] ref_mem [0:255];
    bit            ref_wr  [0:255];

    int               p_new   [N0];
    int               we_mode [N0];
    logic [N0-1:0]    gnt_seen;
    int               glog_idx[$];
    int               glog_cyc[$];
    int               obs_done_cyc;

    task automatic model_reset();
        m_gnt_cyc  = -1;
        m_done_cyc = -1;
        m_last     = N0 - 1;
        m_win      = 0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_rval     = '0;
        exp_rdata  = '0;
    endtask

    task automatic new_req(input int i);
        if0.req[i] = 1'b1;
        if0.we[i]  = (we_mode[i] == 1) ? 1'b1 : (we_mode[i] == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        if0.addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
        if0.wdata[i*DW +: DW] = DW'($urandom);
    endtask

    // Requester behaviour: hold until granted, then drop (with a scrambled payload) or re-request.
    task automatic agents_update();
        for (int i = 0; i < N0; i++) begin
            if (gnt_seen[i]) begin
                if ($urandom_range(0, 99) < p_new[i]) new_req(i);
                else begin
                    if0.req[i] = 1'b0;
                    if0.we[i]  = 1'($urandom_range(0, 1));
                    if0.addr[i*AW +: AW]  = AW'($urandom);
                    if0.wdata[i*DW +: DW] = DW'($urandom);
                end
            end else if (!if0.req[i] && $urandom_range(0, 99) < p_new[i]) begin
                new_req(i);
            end
        end
    endtask

    // One cycle of u0: check outputs against the model, arbitrate in the model, clock, move agents.
    task automatic tick();
        logic [N0-1:0] exp_gnt, exp_done;
        bit rst_now;
        exp_gnt  = (cyc == m_gnt_cyc)  ? (N0'(1) << m_win) : '0;
        exp_done = (cyc == m_done_cyc) ? (N0'(1) << m_win) : '0;
        if (cyc == m_done_cyc && !m_we) exp_rdata = m_rval;
        check("u0_gnt",       32'(if0.gnt),       32'(exp_gnt));
        check("u0_done",      32'(if0.done),      32'(exp_done));
        check("u0_mem_en",    32'(if0.mem_en),    32'(cyc == m_gnt_cyc));
        check("u0_mem_we",    32'(if0.mem_we),    32'(m_we));
        check("u0_mem_addr",  32'(if0.mem_addr),  32'(m_addr));
        check("u0_mem_wdata", 32'(if0.mem_wdata), 32'(m_wdata));
        check("u0_rdata",     32'(if0.rdata),     32'(exp_rdata));
        gnt_seen = if0.gnt;
        if (if0.done != '0) obs_done_cyc = cyc;
        if (if0.gnt != '0) begin
            for (int i = 0; i < N0; i++) if (if0.gnt[i]) begin
                glog_idx.push_back(i);
                glog_cyc.push_back(cyc);
            end
        end
        if (cyc == m_gnt_cyc) begin
            if (m_we) begin
                ref_mem[m_addr[7:0]] = m_wdata;
                ref_wr[m_addr[7:0]]  = 1'b1;
            end else begin
                m_rval = ref_wr[m_addr[7:0]] ? ref_mem[m_addr[7:0]] : init_val(m_addr[7:0]);
            end
        end
        rst_now = rst0;
        if (!rst_now && cyc > m_done_cyc && if0.req != '0) begin
            for (int k = 1; k <= N0; k++) begin
                int j;
                j = (m_last + k) % N0;
                if (if0.req[j]) begin
                    m_win = j;
                    break;
                end
            end
            m_last     = m_win;
            m_we       = if0.we[m_win];
            m_addr     = if0.addr[m_win*AW +: AW];
            m_wdata    = if0.wdata[m_win*DW +: DW];
            m_gnt_cyc  = cyc + 1;
            m_done_cyc = m_we ? cyc + 2 : cyc + 2 + L0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_now) begin
            model_reset();
            gnt_seen = '0;
        end
        agents_update();
    endtask

    task automatic drain();
        int k;
        for (int i = 0; i < N0; i++) p_new[i] = 0;
        k = 0;
        while ((if0.req != '0 || cyc <= m_done_cyc) && k < 200) begin
            tick();
            k++;
        end
        check("drain_bound", 32'(if0.req != '0 || cyc <= m_done_cyc), 32'(0));
    endtask

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, k;
        int exp_seq[5];
        int g1[$];

        rst0 = 1'b1; rst1 = 1'b1;
        if0.req = '0; if0.we = '0; if0.addr = '0; if0.wdata = '0;
        if1.req = '0; if1.we = '0; if1.addr = '0; if1.wdata = '0;
        for (int i = 0; i < N0; i++) begin p_new[i] = 0; we_mode[i] = 0; end
        gnt_seen = '0;
        cyc = 0;
        model_reset();
        step1(); step1();

        // ---- N_REQ=2, RD_LAT=1: reset values, single write, single read ----
        rst1 = 1'b0;
        check("u1_rst_gnt",    32'(if1.gnt), 0);
        check("u1_rst_done",   32'(if1.done), 0);
        check("u1_rst_mem_en", 32'(if1.mem_en), 0);
        check("u1_rst_mem_we", 32'(if1.mem_we), 0);
        check("u1_rst_addr",   32'(if1.mem_addr), 0);
        check("u1_rst_wdata",  32'(if1.mem_wdata), 0);
        check("u1_rst_rdata",  32'(if1.rdata), 0);

        if1.req = 2'b01; if1.we = 2'b01;
        if1.addr[15:0] = 16'h0010; if1.wdata[15:0] = 16'h00AB;
        step1();
        check("u1_wr_gnt",    32'(if1.gnt), 32'h1);
        check("u1_wr_mem_en", 32'(if1.mem_en), 1);
        check("u1_wr_mem_we", 32'(if1.mem_we), 1);
        check("u1_wr_addr",   32'(if1.mem_addr), 32'h0010);
        check("u1_wr_wdata",  32'(if1.mem_wdata), 32'h00AB);
        check("u1_wr_done1",  32'(if1.done), 0);
        if1.req = 2'b00;
        step1();
        check("u1_wr_done",   32'(if1.done), 32'h1);
        check("u1_wr_gnt2",   32'(if1.gnt), 0);
        check("u1_wr_en2",    32'(if1.mem_en), 0);
        step1();
        check("u1_wr_done3",  32'(if1.done), 0);

        if1.req = 2'b10; if1.we = 2'b00; if1.addr[31:16] = 16'h0010;
        step1();
        check("u1_rd_gnt",    32'(if1.gnt), 32'h2);
        check("u1_rd_mem_en", 32'(if1.mem_en), 1);
        check("u1_rd_mem_we", 32'(if1.mem_we), 0);
        if1.req = 2'b00;
        step1();
        check("u1_rd_wait",   32'(if1.done), 0);
        step1();
        check("u1_rd_done",   32'(if1.done), 32'h2);
        check("u1_rd_rdata",  32'(if1.rdata), 32'h00AB);

        // Both requesters held high from reset: grants alternate 0,1,0,1.
        rst1 = 1'b1; step1(); rst1 = 1'b0;
        if1.req = 2'b11; if1.we = 2'b11;
        for (int i = 0; i < 14; i++) begin
            step1();
            check("u1_gnt_done_excl", 32'((if1.gnt & if1.done) != '0), 0);
            if (if1.gnt != '0) g1.push_back(if1.gnt[1] ? 1 : 0);
        end
        if1.req = 2'b00;
        exp_seq = '{0, 1, 0, 1, 0};
        check("u1_alt_count", 32'(g1.size() >= 4), 1);
        for (int i = 0; i < 4; i++) check("u1_alt_order", 32'((i < g1.size()) ? g1[i] : -1), 32'(exp_seq[i]));

        // ---- N_REQ=4, RD_LAT=3: reset, then all requesting continuously ----
        rst0 = 1'b0;
        cyc = 0;
        model_reset();
        for (int i = 0; i < N0; i++) begin p_new[i] = 100; we_mode[i] = 1; new_req(i); end
        glog_idx.delete(); glog_cyc.delete();
        for (int i = 0; i < 16; i++) tick();
        exp_seq = '{0, 1, 2, 3, 0};
        check("u0_rot_count", 32'(glog_idx.size() >= 5), 1);
        for (int i = 0; i < 5; i++)
            check("u0_rot_order", 32'((i < glog_idx.size()) ? glog_idx[i] : -1), 32'(exp_seq[i]));

        // Only requester 2, back-to-back writes: one grant every 3 cycles.
        drain();
        for (int i = 0; i < N0; i++) we_mode[i] = 0;
        p_new[2] = 100; we_mode[2] = 1; new_req(2);
        glog_idx.delete(); glog_cyc.delete();
        for (int i = 0; i < 20; i++) tick();
        check("u0_solo_count", 32'(glog_idx.size() >= 5), 1);
        for (int i = 0; i + 1 < glog_idx.size(); i++) begin
            check("u0_solo_idx",  32'(glog_idx[i]), 2);
            check("u0_solo_gap",  32'(glog_cyc[i+1] - glog_cyc[i]), 3);
        end

        // Single read: done exactly 2+RD_LAT cycles after the request; payload scrambled after gnt.
        drain();
        we_mode[2] = 0; we_mode[1] = 2; new_req(1);
        c0 = cyc; obs_done_cyc = -1; k = 0;
        while (obs_done_cyc < 0 && k < 20) begin tick(); k++; end
        check("u0_rd_latency", 32'(obs_done_cyc - c0), 32'(2 + L0));

        // Reset during WAIT: no done, everything back to reset values, requester 0 wins next.
        drain();
        we_mode[1] = 0; we_mode[3] = 2; new_req(3);
        tick(); tick();
        check("u0_in_wait", 32'(cyc > m_gnt_cyc && cyc < m_done_cyc), 1);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        check("u0_rst_done",   32'(if0.done), 0);
        check("u0_rst_gnt",    32'(if0.gnt), 0);
        check("u0_rst_mem_en", 32'(if0.mem_en), 0);
        check("u0_rst_mem_we", 32'(if0.mem_we), 0);
        check("u0_rst_addr",   32'(if0.mem_addr), 0);
        check("u0_rst_rdata",  32'(if0.rdata), 0);
        we_mode[0] = 1; we_mode[1] = 1; new_req(1); new_req(0);
        glog_idx.delete(); glog_cyc.delete();
        for (int i = 0; i < 4; i++) tick();
        check("u0_post_rst_first", 32'((glog_idx.size() > 0) ? glog_idx[0] : -1), 0);

        // Randomized mixed traffic: sparse, then saturated.
        drain();
        for (int i = 0; i < N0; i++) begin we_mode[i] = 0; p_new[i] = 25; end
        for (int i = 0; i < 500; i++) tick();
        for (int i = 0; i < N0; i++) p_new[i] = 100;
        for (int i = 0; i < 300; i++) tick();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Round-robin arbiter sharing the single-port data DRAM between N_REQ processor cores (each core's store/load path: write_dram, load1–load3 sequence). Sits between the per-core memory request ports and the DRAM macro. One transaction at a time; each access is sequenced through a fixed issue/wait/respond FSM so the DRAM sees at most one enable per transaction.

## Interface
Parameters:
- N_REQ, 2: number of requesters, legal range 2..4
- ADDR_W, 16: DRAM word-address width
- DATA_W, 16: DRAM data width
- RD_LAT, 1: DRAM read latency in cycles (mem_rdata valid RD_LAT cycles after the mem_en cycle), legal 1..7

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester request, level
- we  in  N_REQ  per-requester write (1) / read (0)
- addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_REQ*DATA_W  packed write data, same packing
- gnt  out  N_REQ  one-hot, one-cycle grant pulse
- done  out  N_REQ  one-hot, one-cycle completion pulse
- rdata  out  DATA_W  read data, shared; valid in the done cycle of a read
- mem_en  out  1  DRAM enable, one-cycle pulse per transaction
- mem_we  out  1  DRAM write enable, qualified by mem_en
- mem_addr  out  ADDR_W  DRAM address
- mem_wdata  out  DATA_W  DRAM write data
- mem_rdata  in  DATA_W  DRAM read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit set, pick winner by round robin starting at (last+1) mod N_REQ; latch winner index, we, addr, wdata; next state ISSUE. No req: stay.
- ISSUE (one cycle): gnt[winner]=1, mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values. Write → RESP. Read → WAIT, load wait counter with RD_LAT-1.
- WAIT: counter decrements each cycle; in the cycle counter==0, sample mem_rdata into rdata, next state RESP.
- RESP (one cycle): done[winner]=1, last←winner, next IDLE.
- Requester rule: hold req/we/addr/wdata stable until gnt seen; drop req the cycle after gnt unless issuing a new request. A req still high in IDLE is a new request.
- Payload changes after acceptance are ignored (latched copy used).
- Fairness: a requester that just completed has lowest priority next arbitration; with all requesters continuously requesting, grants rotate 0,1,..,N_REQ-1.
- mem_addr, mem_wdata, mem_we hold last driven values outside ISSUE; only mem_en is authoritative.
- rdata holds its value until the next read capture; unchanged by writes.

## Timing
- Reset (rst sampled high at a clock edge): state IDLE, last=N_REQ-1 (requester 0 wins first), gnt=0, done=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, counter=0.
- Reset mid-transaction: aborted; no done emitted; mem_en low from the next cycle.
- Write: req in cycle 0 → gnt+mem_en cycle 1 → done cycle 2. Latency 2.
- Read: req cycle 0 → gnt+mem_en cycle 1 → WAIT cycles 2..1+RD_LAT → done+rdata cycle 2+RD_LAT.
- Back-to-back: next arbitration in the cycle after RESP; minimum write throughput one per 3 cycles.
- Simultaneous requests in IDLE: exactly one gnt; others wait, no request dropped while req held.
- gnt and done never asserted in the same cycle; at most one bit of each set.

## Structure
- Package dram_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), state width constant, index width function clog2(N_REQ).
- Sub-module rr_picker: combinational round-robin picker (inputs req, last; outputs valid, index). All state in dram_arbiter.

## Test plan
- Reset, then single write req[0], addr=0x0010, wdata=0x00AB → gnt[0] cycle 1, mem_en/mem_we=1 cycle 1, done[0] cycle 2.
- Read req[1] addr=0x0010, RD_LAT=1, DRAM model returns 0x00AB → mem_we=0 at issue, done[1] and rdata=0x00AB at cycle 3.
- req[0] and req[1] high together from reset, held after each done → grant order 0,1,0,1; no consecutive repeat.
- RD_LAT=3 read → exactly 3 WAIT cycles, done at cycle 5; payload changed after gnt ignored.
- rst asserted during WAIT → no done, mem_en low, all outputs at reset values next cycle; next req serviced normally with requester 0 first.
- N_REQ=4, all requesting continuously → grants rotate 0,1,2,3,0; only requester 2 requesting → served every 3 cycles (writes).
